reg_share_arbiter: RTL

Round-robin arbiter that shares one WIDTH-bit edge-triggered storage register among NREQ requesters. Sits between requester logic and the shared DFF bank. It grants exclusive write access, captures the granted requester's data, and returns a one-cycle acknowledge. Optionally, an owner can hold the register for a bounded burst of consecutive writes.

---
 rtl/reg_share_arbiter.sv | 117 +++++++++++
 1 files changed

// File: rtl/reg_share_arbiter.sv
// reg_share_arbiter: round-robin arbiter sharing one register among NREQ writers; REG_SHARE_BURST_LOCK_EN enables bounded burst locking
module reg_share_arbiter #(
  parameter int NREQ     = 4,
  parameter int WIDTH    = 8,
  parameter int MAX_LOCK = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          lock,
  input  logic [NREQ*WIDTH-1:0]    wdata,
  output logic [NREQ-1:0]          gnt,
  output logic                     ack,
  output logic [WIDTH-1:0]         q,
  output logic [WIDTH-1:0]         q_,
  output logic [$clog2(NREQ)-1:0]  owner,
  output logic                     busy
);
  localparam int OW = $clog2(NREQ);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            ack_q, ack_d;
  logic [WIDTH-1:0] q_q, q_d, qn_q, qn_d;
  logic [OW-1:0]   owner_q, owner_d, ptr_q, ptr_d, win, owner_nxt;
  logic [WIDTH-1:0] owner_data;
  assign owner_nxt  = (owner_q == OW'(NREQ-1)) ? '0 : owner_q + 1'b1;
  assign owner_data = wdata[owner_q*WIDTH +: WIDTH];
`ifdef REG_SHARE_BURST_LOCK_EN
  localparam int CW = $clog2(MAX_LOCK+1);
  logic [CW-1:0] lock_cnt_q, lock_cnt_d;
  logic          hold;
  assign hold = lock[owner_q] && (int'(lock_cnt_q) < MAX_LOCK-1);
`else
  logic unused_lock;
  logic hold;
  assign unused_lock = ^lock;
  assign hold = 1'b0;
`endif
  // first set request scanning upward from the rotating pointer
  always_comb begin
    win = ptr_q;
    for (int k = NREQ-1; k >= 0; k--) begin
      int idx;
      idx = int'(ptr_q) + k;
      idx = (idx >= NREQ) ? idx - NREQ : idx;
      if (req[idx]) win = OW'(idx);
    end
  end
  // arbitration and write sequencing
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ack_d   = 1'b0;
    q_d     = q_q;
    qn_d    = qn_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
`ifdef REG_SHARE_BURST_LOCK_EN
    lock_cnt_d = lock_cnt_q;
`endif
    if (state_q == IDLE) begin
      if (|req) begin
        gnt_d   = NREQ'(1) << win;
        owner_d = win;
        state_d = GRANT;
      end
    end else begin
      ptr_d = owner_nxt;
      if (req[owner_q]) begin
        q_d   = owner_data;
        qn_d  = ~owner_data;
        ack_d = 1'b1;
      end
      if (!req[owner_q] || !hold) begin
        gnt_d   = '0;
        state_d = IDLE;
      end
`ifdef REG_SHARE_BURST_LOCK_EN
      lock_cnt_d = (req[owner_q] && hold) ? lock_cnt_q + 1'b1 : '0;
`endif
    end
  end
  // state and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      ack_q   <= 1'b0;
      q_q     <= '0;
      qn_q    <= '1;
      owner_q <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      q_q     <= q_d;
      qn_q    <= qn_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end
`ifdef REG_SHARE_BURST_LOCK_EN
  // burst length counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lock_cnt_q <= '0;
    else     lock_cnt_q <= lock_cnt_d;
  end
`endif
  assign gnt   = gnt_q;
  assign ack   = ack_q;
  assign q     = q_q;
  assign q_    = qn_q;
  assign owner = owner_q;
  assign busy  = (state_q == GRANT);
endmodule
